alu_scan_ctrl: RTL and testbench

//  Sequencer for the 4-bit operand datapath: AND/ADD/XOR/AND mux, output-enable stage, 7-seg transcoder.

---
 rtl/alu_scan_ctrl.sv | 171 +++++++++++++++++
 tb/tb_alu_scan_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_scan_ctrl.sv
// Sequencer for the 4-bit operand datapath: latches operands, steps sel/oe through
// one op (single mode) or all four ops (scan mode), and reports each captured result.
module alu_scan_ctrl #(
    parameter int DWELL = 4,
    parameter int GAP   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       mode,
    input  logic [1:0] op_req,
    input  logic [3:0] a_in,
    input  logic [3:0] b_in,
    input  logic [3:0] alu_res,
    output logic [3:0] in0,
    output logic [3:0] in1,
    output logic [1:0] sel,
    output logic       oe,
    output logic       busy,
    output logic       res_valid,
    output logic [1:0] res_op,
    output logic [3:0] res_data,
    output logic       done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    localparam logic [7:0] DWELL_RELOAD = 8'(DWELL - 1);
    localparam logic [7:0] GAP_RELOAD   = 8'(GAP - 1);

    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       mode_q, mode_d;
    logic [3:0] in0_q, in0_d;
    logic [3:0] in1_q, in1_d;
    logic [1:0] sel_q, sel_d;
    logic       oe_q, oe_d;
    logic       busy_q, busy_d;
    logic       res_valid_q, res_valid_d;
    logic [1:0] res_op_q, res_op_d;
    logic [3:0] res_data_q, res_data_d;
    logic       done_q, done_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        in0_d       = in0_q;
        in1_d       = in1_q;
        sel_d       = sel_q;
        oe_d        = oe_q;
        busy_d      = busy_q;
        res_valid_d = 1'b0;
        res_op_d    = res_op_q;
        res_data_d  = res_data_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    in0_d   = a_in;
                    in1_d   = b_in;
                    mode_d  = mode;
                    sel_d   = mode ? op_req : 2'd0;
                    oe_d    = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = DWELL_RELOAD;
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    oe_d    = 1'b0;
                    sel_d   = 2'd0;
                    busy_d  = 1'b0;
                    cnt_d   = 8'd0;
                end else if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    res_valid_d = 1'b1;
                    res_op_d    = sel_q;
                    res_data_d  = alu_res;
                    // Single mode always ends here; scan mode ends after op 3.
                    if (mode_q || sel_q == 2'd3) begin
                        state_d = S_IDLE;
                        oe_d    = 1'b0;
                        sel_d   = 2'd0;
                        busy_d  = 1'b0;
                        cnt_d   = 8'd0;
                        done_d  = 1'b1;
                    end else if (GAP == 0) begin
                        sel_d = sel_q + 2'd1;
                        cnt_d = DWELL_RELOAD;
                    end else begin
                        state_d = S_GAP;
                        oe_d    = 1'b0;
                        cnt_d   = GAP_RELOAD;
                    end
                end
            end
            S_GAP: begin
                if (abort) begin
                    state_d = S_IDLE;
                    oe_d    = 1'b0;
                    sel_d   = 2'd0;
                    busy_d  = 1'b0;
                    cnt_d   = 8'd0;
                end else if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    sel_d   = sel_q + 2'd1;
                    cnt_d   = DWELL_RELOAD;
                    oe_d    = 1'b1;
                    state_d = S_DRIVE;
                end
            end
            default: begin
                state_d = S_IDLE;
                oe_d    = 1'b0;
                sel_d   = 2'd0;
                busy_d  = 1'b0;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            mode_q      <= 1'b0;
            in0_q       <= 4'd0;
            in1_q       <= 4'd0;
            sel_q       <= 2'd0;
            oe_q        <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_op_q    <= 2'd0;
            res_data_q  <= 4'd0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            in0_q       <= in0_d;
            in1_q       <= in1_d;
            sel_q       <= sel_d;
            oe_q        <= oe_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            res_op_q    <= res_op_d;
            res_data_q  <= res_data_d;
            done_q      <= done_d;
        end
    end

    assign in0       = in0_q;
    assign in1       = in1_q;
    assign sel       = sel_q;
    assign oe        = oe_q;
    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign res_op    = res_op_q;
    assign res_data  = res_data_q;
    assign done      = done_q;

endmodule

// File: tb/tb_alu_scan_ctrl.sv
// Bench for alu_scan_ctrl: two instances (DWELL=4/GAP=1 and DWELL=1/GAP=0) share one
// stimulus stream and are checked every cycle against a schedule-based reference model.
module tb_alu_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       mode;
    logic [1:0] op_req;
    logic [3:0] a_in;
    logic [3:0] b_in;

    logic [1:0][3:0] alu_res_w;
    logic [1:0][3:0] in0_w;
    logic [1:0][3:0] in1_w;
    logic [1:0][1:0] sel_w;
    logic [1:0]      oe_w;
    logic [1:0]      busy_w;
    logic [1:0]      res_valid_w;
    logic [1:0][1:0] res_op_w;
    logic [1:0][3:0] res_data_w;
    logic [1:0]      done_w;

    int n_cmp;
    int n_fail;

    // Model state per configuration
    bit         m_act  [2];
    int         m_k    [2];
    logic       m_mode [2];
    logic [1:0] m_op   [2];
    logic [3:0] e_in0  [2];
    logic [3:0] e_in1  [2];
    logic [1:0] e_sel  [2];
    logic       e_oe   [2];
    logic       e_busy [2];
    logic       e_rv   [2];
    logic [1:0] e_rop  [2];
    logic [3:0] e_rdat [2];
    logic       e_dn   [2];

    function automatic logic [3:0] aluRef(input logic [1:0] op, input logic [3:0] a,
                                          input logic [3:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return 4'((int'(a) + int'(b)) % 16);
            2'd2:    return a ^ b;
            default: return a & b;
        endcase
    endfunction

    function automatic int dwellOf(input int c);
        return (c == 0) ? 4 : 1;
    endfunction

    function automatic int gapOf(input int c);
        return (c == 0) ? 1 : 0;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : cfg
        assign alu_res_w[g] = aluRef(sel_w[g], in0_w[g], in1_w[g]);

        alu_scan_ctrl #(
            .DWELL(dwellOf(g)),
            .GAP  (gapOf(g))
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (start),
            .abort    (abort),
            .mode     (mode),
            .op_req   (op_req),
            .a_in     (a_in),
            .b_in     (b_in),
            .alu_res  (alu_res_w[g]),
            .in0      (in0_w[g]),
            .in1      (in1_w[g]),
            .sel      (sel_w[g]),
            .oe       (oe_w[g]),
            .busy     (busy_w[g]),
            .res_valid(res_valid_w[g]),
            .res_op   (res_op_w[g]),
            .res_data (res_data_w[g]),
            .done     (done_w[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        n_cmp++;
        if (observed != expected) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int c = 0; c < 2; c++) begin
            m_act[c]  = 1'b0;
            m_k[c]    = 0;
            m_mode[c] = 1'b0;
            m_op[c]   = 2'd0;
            e_in0[c]  = 4'd0;
            e_in1[c]  = 4'd0;
            e_sel[c]  = 2'd0;
            e_oe[c]   = 1'b0;
            e_busy[c] = 1'b0;
            e_rv[c]   = 1'b0;
            e_rop[c]  = 2'd0;
            e_rdat[c] = 4'd0;
            e_dn[c]   = 1'b0;
        end
    endtask

    // Op m of a sequence owns edges [m*P, m*P+DWELL) with oe=1, is captured at
    // m*P+DWELL, then blanks for GAP edges; P = DWELL+GAP, edge 0 = acceptance.
    task automatic modelStep();
        int dw, p, n, m;
        logic [1:0] opc;
        if (!rst_n) begin
            modelReset();
            return;
        end
        for (int c = 0; c < 2; c++) begin
            dw = dwellOf(c);
            p  = dwellOf(c) + gapOf(c);
            e_rv[c] = 1'b0;
            e_dn[c] = 1'b0;
            if (m_act[c]) begin
                if (abort) begin
                    m_act[c]  = 1'b0;
                    e_oe[c]   = 1'b0;
                    e_sel[c]  = 2'd0;
                    e_busy[c] = 1'b0;
                end else begin
                    m_k[c]++;
                    n = m_mode[c] ? 1 : 4;
                    if (m_k[c] >= dw && (m_k[c] - dw) % p == 0) begin
                        m = (m_k[c] - dw) / p;
                        opc = m_mode[c] ? m_op[c] : 2'(m);
                        e_rv[c]   = 1'b1;
                        e_rop[c]  = opc;
                        e_rdat[c] = aluRef(opc, e_in0[c], e_in1[c]);
                        if (m == n - 1) begin
                            m_act[c]  = 1'b0;
                            e_oe[c]   = 1'b0;
                            e_sel[c]  = 2'd0;
                            e_busy[c] = 1'b0;
                            e_dn[c]   = 1'b1;
                        end
                    end
                    if (m_act[c]) begin
                        e_oe[c]  = (m_k[c] % p) < dw;
                        e_sel[c] = m_mode[c] ? m_op[c] : 2'(m_k[c] / p);
                    end
                end
            end else if (start && !abort) begin
                m_act[c]  = 1'b1;
                m_k[c]    = 0;
                m_mode[c] = mode;
                m_op[c]   = op_req;
                e_in0[c]  = a_in;
                e_in1[c]  = b_in;
                e_sel[c]  = mode ? op_req : 2'd0;
                e_oe[c]   = 1'b1;
                e_busy[c] = 1'b1;
            end
        end
    endtask

    task automatic compareAll();
        for (int c = 0; c < 2; c++) begin
            checkOutput($sformatf("c%0d.in0", c), int'(in0_w[c]), int'(e_in0[c]));
            checkOutput($sformatf("c%0d.in1", c), int'(in1_w[c]), int'(e_in1[c]));
            checkOutput($sformatf("c%0d.sel", c), int'(sel_w[c]), int'(e_sel[c]));
            checkOutput($sformatf("c%0d.oe", c), int'(oe_w[c]), int'(e_oe[c]));
            checkOutput($sformatf("c%0d.busy", c), int'(busy_w[c]), int'(e_busy[c]));
            checkOutput($sformatf("c%0d.res_valid", c), int'(res_valid_w[c]), int'(e_rv[c]));
            checkOutput($sformatf("c%0d.res_op", c), int'(res_op_w[c]), int'(e_rop[c]));
            checkOutput($sformatf("c%0d.res_data", c), int'(res_data_w[c]), int'(e_rdat[c]));
            checkOutput($sformatf("c%0d.done", c), int'(done_w[c]), int'(e_dn[c]));
        end
    endtask

    task automatic applyStimulus(input logic st, input logic ab, input logic md,
                                 input logic [1:0] op, input logic [3:0] a,
                                 input logic [3:0] b);
        @(negedge clk);
        rst_n  = 1'b1;
        start  = st;
        abort  = ab;
        mode   = md;
        op_req = op;
        a_in   = a;
        b_in   = b;
        @(posedge clk);
        modelStep();
        #1;
        compareAll();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0);
    endtask

    task automatic asyncResetMidCycle();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        modelReset();
        compareAll();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        mode   = 1'b0;
        op_req = 2'd0;
        a_in   = 4'd0;
        b_in   = 4'd0;
        modelReset();
        #3;
        compareAll();
        idleCycles(3);

        $display("[TB] single mode ADD 9+8");
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd1, 4'h9, 4'h8);
        idleCycles(7);

        $display("[TB] scan mode C/A");
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 4'hC, 4'hA);
        idleCycles(24);

        $display("[TB] abort before second scan capture");
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 4'h5, 4'h3);
        idleCycles(8);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 4'h0);
        idleCycles(6);

        $display("[TB] start held high back-to-back");
        for (int i = 0; i < 45; i++) applyStimulus(1'b1, 1'b0, 1'b0, 2'd2, 4'h7, 4'hE);
        idleCycles(22);

        $display("[TB] start with abort in idle");
        applyStimulus(1'b1, 1'b1, 1'b1, 2'd3, 4'hF, 4'h1);
        idleCycles(3);

        $display("[TB] async reset during DRIVE");
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 4'h6, 4'h9);
        idleCycles(2);
        asyncResetMidCycle();
        idleCycles(4);

        $display("[TB] random stimulus");
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                asyncResetMidCycle();
            end
            applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
                          1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
        idleCycles(25);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
